// File: rtl/regbank_write_arbiter.sv
// rtl/regbank_write_arbiter.sv - register-bank write-port arbiter for NUM_REQ writeback sources
module regbank_write_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 5,
  parameter int RR_MODE = 1,
  parameter int ZERO_RO = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        arb_en,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        wr_en,
  output logic [ADDR_W-1:0]           wr_addr,
  output logic [DATA_W-1:0]           wr_data,
  output logic [(1<<ADDR_W)-1:0]      pend_mask,
  output logic                        drop
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int NREG  = 1 << ADDR_W;

  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  gnt_idx;
  logic              found;
  logic              grant_vld;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  int                idx;

  // Pick the first valid source, scanning from rr_ptr (round-robin) or from 0 (fixed priority)
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (RR_MODE != 0) ? (int'(rr_ptr) + k) % NUM_REQ : k;
      if (!found && req_valid[idx]) begin
        found   = 1'b1;
        gnt_idx = idx[PTR_W-1:0];
      end
    end
  end

  // Reset holds all grants low; arb_en gates new grants immediately
  assign grant_vld = rst_n && arb_en && found;
  assign sel_addr  = req_addr[gnt_idx*ADDR_W +: ADDR_W];
  assign sel_data  = req_data[gnt_idx*DATA_W +: DATA_W];

  // One-hot ready toward the granted source only
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = grant_vld && (gnt_idx == PTR_W'(i));
    end
  end

  // Output stage: capture the granted write, turn register-0 writes into a drop pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      drop    <= 1'b0;
      rr_ptr  <= '0;
    end else begin
      wr_en <= 1'b0;
      drop  <= 1'b0;
      if (grant_vld) begin
        wr_addr <= sel_addr;
        wr_data <= sel_data;
        if ((ZERO_RO != 0) && (sel_addr == '0)) begin
          drop <= 1'b1;
        end else begin
          wr_en <= 1'b1;
        end
        if (RR_MODE != 0) begin
          rr_ptr <= (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
      end
    end
  end

  // Pending-write mask: the register currently sitting in the output stage
  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < NREG; i++) begin
      pend_mask[i] = wr_en && (wr_addr == ADDR_W'(i));
    end
  end

endmodule
